// File: rtl/conv3x3_seq_if.sv
// conv3x3_seq stream bundle
// raster pixels in, three vertical taps plus status out
interface conv3x3_seq_if #(
  parameter int XWIDTH = 12
);
  logic              iFrameStart;
  logic              iDVAL;
  logic [XWIDTH-1:0] iDATA;
  logic [XWIDTH-1:0] oX0;
  logic [XWIDTH-1:0] oX1;
  logic [XWIDTH-1:0] oX2;
  logic              oEN;
  logic              oEdge;
  logic              oBusy;
  logic              oFrameDone;

  modport master (
    output iFrameStart, iDVAL, iDATA,
    input  oX0, oX1, oX2, oEN, oEdge,
    input  oBusy, oFrameDone
  );

  modport slave (
    input  iFrameStart, iDVAL, iDATA,
    output oX0, oX1, oX2, oEN, oEdge,
    output oBusy, oFrameDone
  );
endinterface

// File: rtl/conv3x3_seq.sv
// conv3x3_seq: line-buffered 3-tap front end for the Sobel stage
// two line RAMs give rows r-2 / r-1 under the current pixel
module conv3x3_seq #(
  parameter int XWIDTH = 12,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int CW     = 10,
  parameter int RW     = 9
) (
  input  logic iCLK,
  input  logic iRST,
  conv3x3_seq_if.slave bus
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam bit            SHORT    = (IMG_H <= 2);
  localparam logic [RW-1:0] FILL_LAST =
    SHORT ? ROW_LAST : RW'(1);

  typedef enum logic [1:0] {
    IDLE, FILL, RUN, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d, ec;
  logic [RW-1:0]     row_q, row_d, er;
  logic              acc, lcol;
  logic [XWIDTH-1:0] a_rd, b_rd;
  logic [XWIDTH-1:0] x0_q, x1_q, x2_q;
  logic              en_q, edge_q, done_q;

  logic [XWIDTH-1:0] ram_a [IMG_W];
  logic [XWIDTH-1:0] ram_b [IMG_W];

  // A restart cycle's pixel is (0,0) of the new frame
  always_comb begin
    ec   = bus.iFrameStart ? '0 : col_q;
    er   = bus.iFrameStart ? '0 : row_q;
    acc  = bus.iDVAL &&
           (bus.iFrameStart ||
            state_q == FILL ||
            state_q == RUN);
    lcol = (ec == COL_LAST);
    a_rd = ram_a[ec];
    b_rd = ram_b[ec];
  end

  // Next counters and next state
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    if (bus.iFrameStart) begin
      col_d = '0;
      row_d = '0;
    end
    if (acc) begin
      if (lcol) begin
        col_d = '0;
        row_d = (er == ROW_LAST) ? '0 : er + 1'b1;
      end else begin
        col_d = ec + 1'b1;
      end
    end
    unique case (state_q)
      IDLE: state_d = IDLE;
      FILL:
        if (acc && lcol && er == FILL_LAST)
          state_d = SHORT ? DONE : RUN;
      RUN:
        if (acc && lcol && er == ROW_LAST)
          state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.iFrameStart) state_d = FILL;
  end

  // FSM, counters and registered tap outputs
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      en_q    <= 1'b0;
      edge_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      done_q  <= (state_q == DONE);
      en_q    <= acc;
      edge_q  <= acc && er > RW'(1) && ec > CW'(1);
      if (acc) begin
        x2_q <= bus.iDATA;
        x1_q <= (er == '0) ? '0 : a_rd;
        x0_q <= (er > RW'(1)) ? b_rd : '0;
      end
    end
  end

  // Line RAMs: read-before-write shift A -> B
  always_ff @(posedge iCLK) begin
    if (acc) begin
      ram_a[ec] <= bus.iDATA;
      ram_b[ec] <= a_rd;
    end
  end

  assign bus.oX0        = x0_q;
  assign bus.oX1        = x1_q;
  assign bus.oX2        = x2_q;
  assign bus.oEN        = en_q;
  assign bus.oEdge      = edge_q;
  assign bus.oFrameDone = done_q;
  assign bus.oBusy      = (state_q == FILL) ||
                          (state_q == RUN);

endmodule
